// File: rtl/npc_pkg.sv
// npc_pkg: definitions shared by the NPC core pipeline stages (IFU, decode).
//   - ifu_state_e    : instruction-fetch FSM states
//   - XLEN           : datapath width; bus widths are derived from it
//   - RESET_PC_DEFAULT, EBREAK_INST : architectural constants
//   - if_to_id_t     : IF->ID payload layout, with pc in the upper half
package npc_pkg;

  localparam int unsigned XLEN           = 32;
  localparam int unsigned IF_TO_ID_BUS_W = 2 * XLEN;
  localparam int unsigned ID_TO_IF_BUS_W = XLEN;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h8000_0000;
  // An ebreak is substituted on a fetch fault so that decode ends the simulation.
  localparam logic [XLEN-1:0] EBREAK_INST      = 32'h0010_0073;

  typedef enum logic [1:0] {
    IFU_FETCH = 2'd0,
    IFU_WAIT  = 2'd1,
    IFU_SEND  = 2'd2,
    IFU_NPC   = 2'd3
  } ifu_state_e;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] inst;
  } if_to_id_t;

endpackage

// File: rtl/ifu_perf_cnt.sv
// ifu_perf_cnt: fetch and stall event counters for the IFU.
// This module is instantiated only when IFU_PERF_EN is defined.
//   clk, rst      : core clock; asynchronous active-high reset
//   fetch_inc_i   : a memory response was accepted
//   stall_inc_i   : the IFU was blocked on memory this cycle
//   fetch_cnt_o   : count of accepted responses (wraps at 2^32)
//   stall_cnt_o   : count of memory stall cycles (wraps at 2^32)
module ifu_perf_cnt
  import npc_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_inc_i,
  input  logic        stall_inc_i,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] stall_cnt_o
);

  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (fetch_inc_i) fetch_cnt_d = fetch_cnt_q + 32'd1;
    if (stall_inc_i) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign fetch_cnt_o = fetch_cnt_q;
  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit of the multi-cycle NPC core.
// The IFU fetches one instruction at the current pc, passes {pc, inst} to
// decode, and then waits for decode to return the next pc.
//   clk, rst            : core clock; asynchronous active-high reset
//   imem_req_*          : request channel (valid/ready) and imem_addr
//   imem_resp_*         : response channel (valid/ready), imem_rdata, imem_resp_err
//   if_to_id_*          : {pc, inst} to decode (valid/ready)
//   id_to_if_*          : dnpc from decode (valid/ready)
//   fetch_misalign      : sticky flag; set when a dnpc had bits [1:0] != 0
// When the macro IFU_PERF_EN is defined, the module also has the outputs
// perf_fetch_cnt and perf_stall_cnt.
module ifu
  import npc_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH = XLEN,
  parameter logic [DATA_WIDTH-1:0] RESET_PC   = DATA_WIDTH'(RESET_PC_DEFAULT)
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    imem_req_valid,
  input  logic                    imem_req_ready,
  output logic [DATA_WIDTH-1:0]   imem_addr,
  input  logic                    imem_resp_valid,
  output logic                    imem_resp_ready,
  input  logic [DATA_WIDTH-1:0]   imem_rdata,
  input  logic                    imem_resp_err,
  output logic [2*DATA_WIDTH-1:0] if_to_id_bus,
  output logic                    if_to_id_valid,
  input  logic                    id_to_if_ready,
  input  logic [DATA_WIDTH-1:0]   id_to_if_bus,
  input  logic                    id_to_if_valid,
  output logic                    if_to_id_ready,
  output logic                    fetch_misalign
`ifdef IFU_PERF_EN
  ,
  output logic [31:0]             perf_fetch_cnt,
  output logic [31:0]             perf_stall_cnt
`endif
);

  ifu_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] inst_q, inst_d;
  logic                  misalign_q, misalign_d;
  logic                  req_valid_q, req_valid_d;
  logic                  resp_ready_q, resp_ready_d;
  logic                  id_valid_q, id_valid_d;
  logic                  npc_ready_q, npc_ready_d;

  // Each handshake uses the registered valid or ready of its own state.
  logic req_fire, resp_fire, send_fire, npc_fire;
  assign req_fire  = req_valid_q  & imem_req_ready;
  assign resp_fire = resp_ready_q & imem_resp_valid;
  assign send_fire = id_valid_q   & id_to_if_ready;
  assign npc_fire  = npc_ready_q  & id_to_if_valid;

  // Next-state logic, datapath, and output decode.
  // The valid/ready outputs are registered versions of the decode of state_d.
  // As a result, they are all low during reset and change on the same edge as the state.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    misalign_d = misalign_q;

    unique case (state_q)
      IFU_FETCH: begin
        if (req_fire) state_d = IFU_WAIT;
      end
      IFU_WAIT: begin
        if (resp_fire) begin
          inst_d  = imem_resp_err ? DATA_WIDTH'(EBREAK_INST) : imem_rdata;
          state_d = IFU_SEND;
        end
      end
      IFU_SEND: begin
        if (send_fire) state_d = IFU_NPC;
      end
      IFU_NPC: begin
        if (npc_fire) begin
          // The low bits are dropped so that fetch stays word aligned.
          // The flag records that a misaligned dnpc was received.
          pc_d = {id_to_if_bus[DATA_WIDTH-1:2], 2'b00};
          if (id_to_if_bus[1:0] != 2'b00) misalign_d = 1'b1;
          state_d = IFU_FETCH;
        end
      end
      default: state_d = IFU_FETCH;
    endcase

    req_valid_d  = (state_d == IFU_FETCH);
    resp_ready_d = (state_d == IFU_WAIT);
    id_valid_d   = (state_d == IFU_SEND);
    npc_ready_d  = (state_d == IFU_NPC);
  end

  // State, pc, instruction, and registered handshake outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IFU_FETCH;
      pc_q         <= RESET_PC;
      inst_q       <= '0;
      misalign_q   <= 1'b0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      id_valid_q   <= 1'b0;
      npc_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      misalign_q   <= misalign_d;
      req_valid_q  <= req_valid_d;
      resp_ready_q <= resp_ready_d;
      id_valid_q   <= id_valid_d;
      npc_ready_q  <= npc_ready_d;
    end
  end

  assign imem_req_valid  = req_valid_q;
  assign imem_addr       = pc_q;
  assign imem_resp_ready = resp_ready_q;
  assign if_to_id_valid  = id_valid_q;
  assign if_to_id_bus    = {pc_q, inst_q};
  assign if_to_id_ready  = npc_ready_q;
  assign fetch_misalign  = misalign_q;

`ifdef IFU_PERF_EN
  // A stall is a cycle in which the IFU offers a handshake and memory does not complete it.
  ifu_perf_cnt u_perf_cnt (
    .clk         (clk),
    .rst         (rst),
    .fetch_inc_i (resp_fire),
    .stall_inc_i ((req_valid_q & ~imem_req_ready) | (resp_ready_q & ~imem_resp_valid)),
    .fetch_cnt_o (perf_fetch_cnt),
    .stall_cnt_o (perf_stall_cnt)
  );
`endif

endmodule

// File: tb/tb_ifu.sv
// tb_ifu: directed self-checking bench for ifu.
// A scoreboard queue holds the expected {pc, inst} for each response driven by the bench.
// Each entry is compared against if_to_id_bus at the decode handshake.
module tb_ifu;
  import npc_pkg::*;

  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_resp_valid;
  logic        imem_resp_ready;
  logic [31:0] imem_rdata;
  logic        imem_resp_err;
  logic [63:0] if_to_id_bus;
  logic        if_to_id_valid;
  logic        id_to_if_ready;
  logic [31:0] id_to_if_bus;
  logic        id_to_if_valid;
  logic        if_to_id_ready;
  logic        fetch_misalign;
`ifdef IFU_PERF_EN
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  ifu dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_ready  (imem_req_ready),
    .imem_addr       (imem_addr),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_ready (imem_resp_ready),
    .imem_rdata      (imem_rdata),
    .imem_resp_err   (imem_resp_err),
    .if_to_id_bus    (if_to_id_bus),
    .if_to_id_valid  (if_to_id_valid),
    .id_to_if_ready  (id_to_if_ready),
    .id_to_if_bus    (id_to_if_bus),
    .id_to_if_valid  (id_to_if_valid),
    .if_to_id_ready  (if_to_id_ready),
    .fetch_misalign  (fetch_misalign)
`ifdef IFU_PERF_EN
    ,
    .perf_fetch_cnt  (perf_fetch_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          req_start = 0;
  logic [63:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one fetch/send/npc round trip. Each handshake can be delayed by a given number of wait cycles.
  task automatic do_instr(input logic [31:0] exp_pc, input logic [31:0] inst, input logic err,
                          input int req_wait, input int resp_wait, input int dec_wait,
                          input logic [31:0] dnpc, input string tag);
    int          budget;
    logic [63:0] exp_bus;
`ifdef IFU_PERF_EN
    logic [31:0] stall0;
    logic [31:0] fetch0;
`endif
    budget = 0;
    while (imem_req_valid !== 1'b1 && budget < 20) begin
      tick();
      budget++;
    end
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'd1);
    if (imem_req_valid !== 1'b1) return;
    req_start = cyc;
    chk({tag, "_addr"}, 64'(imem_addr), 64'(exp_pc));
`ifdef IFU_PERF_EN
    stall0 = perf_stall_cnt;
    fetch0 = perf_fetch_cnt;
`endif
    imem_req_ready = 1'b0;
    for (int i = 0; i < req_wait; i++) begin
      tick();
      chk({tag, "_req_hold"}, 64'({imem_req_valid, imem_resp_ready, imem_addr}), 64'({2'b10, exp_pc}));
    end
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk({tag, "_in_wait"}, 64'({imem_req_valid, imem_resp_ready, if_to_id_valid}), 64'(3'b010));
    for (int i = 0; i < resp_wait; i++) begin
      tick();
      chk({tag, "_resp_hold"}, 64'({imem_resp_ready, if_to_id_valid}), 64'(2'b10));
    end
    imem_resp_valid = 1'b1;
    imem_rdata      = inst;
    imem_resp_err   = err;
    exp_q.push_back({exp_pc, err ? EBREAK_INST : inst});
    tick();
    imem_resp_valid = 1'b0;
    imem_resp_err   = 1'b0;
    imem_rdata      = $urandom;
    chk({tag, "_send_valid"}, 64'({if_to_id_valid, imem_resp_ready}), 64'(2'b10));
`ifdef IFU_PERF_EN
    chk({tag, "_perf_stall"}, 64'(perf_stall_cnt - stall0), 64'(req_wait + resp_wait));
    chk({tag, "_perf_fetch"}, 64'(perf_fetch_cnt - fetch0), 64'd1);
`endif
    chk({tag, "_sb_nonempty"}, 64'(exp_q.size() != 0), 64'd1);
    exp_bus = (exp_q.size() != 0) ? exp_q.pop_front() : 64'h0;
    id_to_if_ready = 1'b0;
    for (int i = 0; i < dec_wait; i++) begin
      tick();
      chk({tag, "_dec_bus_hold"}, if_to_id_bus, exp_bus);
      chk({tag, "_dec_flags"}, 64'({if_to_id_valid, if_to_id_ready, imem_req_valid}), 64'(3'b100));
    end
    id_to_if_ready = 1'b1;
    chk({tag, "_bus"}, if_to_id_bus, exp_bus);
    tick();
    id_to_if_ready = 1'b0;
    chk({tag, "_in_npc"}, 64'({if_to_id_valid, if_to_id_ready, imem_req_valid}), 64'(3'b010));
    id_to_if_valid = 1'b1;
    id_to_if_bus   = dnpc;
    tick();
    id_to_if_valid = 1'b0;
    id_to_if_bus   = $urandom;
    chk({tag, "_next_fetch"}, 64'({if_to_id_ready, imem_req_valid}), 64'(2'b01));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded its time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b0;
    imem_resp_valid = 1'b0;
    imem_rdata      = '0;
    imem_resp_err   = 1'b0;
    id_to_if_ready  = 1'b0;
    id_to_if_bus    = '0;
    id_to_if_valid  = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_flags", 64'({imem_req_valid, imem_resp_ready, if_to_id_valid, if_to_id_ready, fetch_misalign}), 64'(5'b0));
    chk("rst_addr", 64'(imem_addr), 64'(RPC));
    chk("rst_bus", if_to_id_bus, {RPC, 32'h0});
`ifdef IFU_PERF_EN
    chk("rst_perf", 64'({perf_fetch_cnt, perf_stall_cnt}), 64'h0);
`endif
    rst = 1'b0;
    tick();
    chk("first_req", 64'({imem_req_valid, imem_addr}), 64'({1'b1, RPC}));

    // Zero-wait loop of 4 cycles per instruction
    do_instr(RPC, 32'h0000_0413, 1'b0, 0, 0, 0, 32'h8000_0004, "t1");
    chk("t1_loop4", 64'(cyc - req_start), 64'd4);
    chk("t1_addr_next", 64'(imem_addr), 64'h8000_0004);

    // Memory back-pressure
    do_instr(32'h8000_0004, 32'h0010_0093, 1'b0, 3, 2, 0, 32'h8000_0008, "t2");

    // Decode stall
    do_instr(32'h8000_0008, 32'h0020_0113, 1'b0, 0, 0, 4, 32'h8000_0100, "t3");

    // Taken jump followed by a misaligned dnpc
    chk("t4_pre_misalign", 64'(fetch_misalign), 64'd0);
    do_instr(32'h8000_0100, 32'h0030_0193, 1'b0, 0, 0, 0, 32'h8000_0102, "t4");
    chk("t4_misalign", 64'(fetch_misalign), 64'd1);

    // Access fault delivers ebreak; the misalign flag stays set
    do_instr(32'h8000_0100, 32'hDEAD_BEEF, 1'b1, 0, 0, 0, 32'h8000_0104, "t5");
    chk("t5_misalign_sticky", 64'(fetch_misalign), 64'd1);

    // Reset in WAIT while a response arrives
    chk("t6_req", 64'({imem_req_valid, imem_addr}), 64'({1'b1, 32'h8000_0104}));
    imem_req_ready = 1'b1;
    tick();
    imem_req_ready = 1'b0;
    chk("t6_wait", 64'(imem_resp_ready), 64'd1);
    rst             = 1'b1;
    imem_resp_valid = 1'b1;
    imem_rdata      = 32'h1234_5678;
    #1;
    chk("t6_rst_async", 64'({imem_req_valid, imem_resp_ready, if_to_id_valid, if_to_id_ready}), 64'(4'b0));
    tick();
    chk("t6_rst_flags", 64'({imem_req_valid, imem_resp_ready, if_to_id_valid, if_to_id_ready, fetch_misalign}), 64'(5'b0));
    chk("t6_rst_addr", 64'(imem_addr), 64'(RPC));
    chk("t6_rst_bus", if_to_id_bus, {RPC, 32'h0});
`ifdef IFU_PERF_EN
    chk("t6_perf_fetch", 64'(perf_fetch_cnt), 64'd0);
`endif
    rst             = 1'b0;
    imem_resp_valid = 1'b0;
    tick();
    chk("t6_restart", 64'({imem_req_valid, imem_resp_ready, if_to_id_valid}), 64'(3'b100));
    do_instr(RPC, 32'h0000_0513, 1'b0, 1, 1, 1, 32'h8000_0004, "t7");

    chk("sb_drained", 64'(exp_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
